// File: rtl/opb_status_pkg.sv
// Shared definitions for the OPB status bank: register offsets, CTRL bit
// positions and the per-channel update mode.
package opb_status_pkg;

    typedef enum logic [1:0] {
        LIVE,
        STICKY,
        SNAP
    } chan_mode_e;

    localparam int CTRL_OFF    = 'h00;
    localparam int STAT_OFF    = 'h04;
    localparam int CH_BASE_OFF = 'h08;

    localparam int SNAP_BIT = 0;
    localparam int CLR_BIT  = 1;

    // Sticky wins when a channel is flagged in both masks.
    function automatic chan_mode_e chan_mode_of(input logic sticky, input logic snap);
        if (sticky) return STICKY;
        if (snap)   return SNAP;
        return LIVE;
    endfunction

endpackage

// File: rtl/opb_status_chan.sv
// One status channel register: follows its input (live), accumulates with
// clear-on-mask (sticky) or loads on a shared capture strobe (snapshot).
module opb_status_chan
    import opb_status_pkg::*;
#(
    parameter chan_mode_e MODE = LIVE,
    parameter int         W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] clr_mask_i,
    input  logic         snap_i,
    output logic [W-1:0] ch_o
);

    logic [W-1:0] ch_d;
    logic [W-1:0] ch_q;
    logic         unused_ok;

    // NOTE: next state is formed with blocking '=' after a default assignment, so no latch is inferred; only the flop uses '<='.
    always_comb begin
        ch_d = ch_q;
        case (MODE)
            STICKY:  ch_d = (ch_q & ~clr_mask_i) | in_i;  // a set in the clear cycle survives
            SNAP:    if (snap_i) ch_d = in_i;
            default: ch_d = in_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    assign ch_o = ch_q;

    // Clear mask and strobe are only consumed by some modes.
    assign unused_ok = ^{clr_mask_i, snap_i};

endmodule

// File: rtl/opb_status_bank.sv
// OPB slave window exposing C_N_CH user status channels plus a CTRL/STAT pair;
// decode, single-cycle ack and the registered read mux live here.
module opb_status_bank
    import opb_status_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_N_CH        = 4,
    parameter int          C_USER_W      = 32,
    parameter logic [15:0] C_STICKY_MASK = '0,
    parameter logic [15:0] C_SNAP_MASK   = '0
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
    input  logic                         OPB_RNW,
    input  logic                         OPB_select,
    input  logic                         OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
    output logic                         Sl_xferAck,
    output logic                         Sl_errAck,
    output logic                         Sl_retry,
    output logic                         Sl_toutSup,
    input  logic [C_N_CH*C_USER_W-1:0]   user_data_in,
    input  logic                         snap_in,
    output logic [15:0]                  snap_count
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;
    localparam int NB = DW / 8;
    localparam int IW = AW - 2;
    localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);
    localparam logic [AW-1:0] SPAN = AW'(C_HIGHADDR - C_BASEADDR);

    logic [AW-1:0]       addr;
    logic [AW-1:0]       offset;
    logic [IW-1:0]       word_idx;
    logic [DW-1:0]       wdata;
    logic [DW-1:0]       be_mask;
    logic [DW-1:0]       wdata_m;
    logic [NB-1:0]       be;
    logic                hit;
    logic                req;
    logic                wr;
    logic                ctrl_wr;
    logic                snap_now;
    logic                clr_all;
    logic                ack_q;
    logic [DW-1:0]       rdata_d;
    logic [DW-1:0]       rdata_q;
    logic [15:0]         snap_cnt_q;
    logic [C_USER_W-1:0] ch_val [C_N_CH];
    logic                unused_ok;

    // Big-endian OPB vectors land MSB-to-MSB, so bus bit 0 becomes register bit 31.
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;

    // An address below the base wraps to a huge offset, so one compare bounds both ends.
    assign offset   = addr - BASE;
    assign word_idx = offset[AW-1:2];
    assign hit      = OPB_select && (offset <= SPAN);
    assign req      = hit && !ack_q;
    assign wr       = req && !OPB_RNW;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{be[b]}};
        end
    end

    assign wdata_m  = wdata & be_mask;
    assign ctrl_wr  = wr && (word_idx == IW'(CTRL_OFF / 4));
    assign snap_now = snap_in || (ctrl_wr && wdata_m[SNAP_BIT]);
    assign clr_all  = ctrl_wr && wdata_m[CLR_BIT];

    for (genvar i = 0; i < C_N_CH; i++) begin : g_ch
        logic                ch_wr;
        logic [C_USER_W-1:0] clr_mask;

        assign ch_wr    = wr && (word_idx == IW'(CH_BASE_OFF / 4 + i));
        assign clr_mask = clr_all ? '1 : (ch_wr ? wdata_m[C_USER_W-1:0] : '0);

        opb_status_chan #(
            .MODE (chan_mode_of(C_STICKY_MASK[i], C_SNAP_MASK[i])),
            .W    (C_USER_W)
        ) u_chan (
            .clk        (OPB_Clk),
            .rst        (OPB_Rst),
            .in_i       (user_data_in[i*C_USER_W +: C_USER_W]),
            .clr_mask_i (clr_mask),
            .snap_i     (snap_now),
            .ch_o       (ch_val[i])
        );
    end

    // CTRL and unmapped offsets fall through to zero.
    always_comb begin
        rdata_d = '0;
        if (req && OPB_RNW) begin
            if (word_idx == IW'(STAT_OFF / 4)) begin
                rdata_d[15:0] = snap_cnt_q;
            end
            for (int i = 0; i < C_N_CH; i++) begin
                if (word_idx == IW'(CH_BASE_OFF / 4 + i)) begin
                    rdata_d[C_USER_W-1:0] = ch_val[i];
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            snap_cnt_q <= '0;
        end else begin
            ack_q   <= req;
            rdata_q <= rdata_d;
            if (snap_now) begin
                snap_cnt_q <= snap_cnt_q + 16'd1;
            end
        end
    end

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_count = snap_cnt_q;

    assign unused_ok = ^{OPB_seqAddr, offset[1:0], wdata_m};

endmodule

// File: tb/tb_opb_status_bank.sv
// Directed bench: an all-live bank and a mixed bank (ch1 sticky, ch2/3 snapshot)
// share one OPB master; expected values are hand-computed constants.
module tb_opb_status_bank;

    localparam int UW = 32;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [0:31]     abus;
    logic [0:3]      be;
    logic [0:31]     dbus;
    logic            rnw;
    logic            sel;
    logic            seq;
    logic            snap_in;
    logic [NC*UW-1:0] user_live;
    logic [NC*UW-1:0] user_mix;

    logic [0:31] dbus_live, dbus_mix;
    logic        ack_live, ack_mix;
    logic        err_live, retry_live, tout_live;
    logic        err_mix, retry_mix, tout_mix;
    logic [15:0] cnt_live, cnt_mix;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_wrap;
    logic [15:0] exp_cnt;
    logic [1:0]  r_ack;
    logic [31:0] r_live, r_mix, r_side;

    always #5 clk = ~clk;

    opb_status_bank #(
        .C_N_CH(NC), .C_USER_W(UW), .C_STICKY_MASK(16'h0000), .C_SNAP_MASK(16'h0000)
    ) dut_live (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(dbus_live), .Sl_xferAck(ack_live), .Sl_errAck(err_live),
        .Sl_retry(retry_live), .Sl_toutSup(tout_live),
        .user_data_in(user_live), .snap_in(snap_in), .snap_count(cnt_live)
    );

    opb_status_bank #(
        .C_N_CH(NC), .C_USER_W(UW), .C_STICKY_MASK(16'h0002), .C_SNAP_MASK(16'h000C)
    ) dut_mix (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(dbus_mix), .Sl_xferAck(ack_mix), .Sl_errAck(err_mix),
        .Sl_retry(retry_mix), .Sl_toutSup(tout_mix),
        .user_data_in(user_mix), .snap_in(snap_in), .snap_count(cnt_mix)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer: request cycle, ack cycle (captured), then one idle cycle.
    // r_side collects any bus activity seen in the request and idle cycles.
    task automatic xfer(input logic is_rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ben, input logic snap);
        abus = addr; rnw = is_rd; dbus = wd; be = ben; sel = 1'b1; snap_in = snap;
        #1;
        r_side = dbus_live | dbus_mix | {30'b0, ack_live, ack_mix};
        @(posedge clk); #1;
        snap_in = 1'b0;
        r_ack  = {ack_live, ack_mix};
        r_live = dbus_live;
        r_mix  = dbus_mix;
        sel = 1'b0; rnw = 1'b0; dbus = '0; abus = '0; be = '0;
        @(posedge clk); #1;
        r_side = r_side | dbus_live | dbus_mix | {30'b0, ack_live, ack_mix};
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(1'b1, addr, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ben,
                      input logic snap);
        xfer(1'b0, addr, wd, ben, snap);
    endtask

    initial begin
        abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0; snap_in = 1'b0;
        user_live = '0; user_mix = '0; exp_cnt = 16'd0;

        // Reset state.
        #12;
        check("rst_ack", {30'b0, ack_live, ack_mix}, 32'h0);
        check("rst_dbus", dbus_live | dbus_mix, 32'h0);
        check("rst_cnt", {cnt_live, cnt_mix}, 32'h0);
        check("tied_off", {26'b0, err_live, retry_live, tout_live, err_mix, retry_mix, tout_mix}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        // Reset asserted in the middle of an acked STAT read.
        snap_in = 1'b1; tick(1); snap_in = 1'b0;
        exp_cnt = 16'd1;
        check("cnt_one", {16'h0, cnt_mix}, {16'h0, exp_cnt});
        abus = 32'h4; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'b0, ack_mix}, 32'h1);
        check("pre_rst_stat", dbus_mix, {16'h0, exp_cnt});
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'b0, ack_mix}, 32'h0);
        check("mid_rst_dbus", dbus_mix, 32'h0);
        check("mid_rst_cnt", {16'h0, cnt_mix}, 32'h0);
        exp_cnt = 16'd0;
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
        rst = 1'b0;
        tick(1);
        rd(32'h04);
        check("stat_after_rst", r_mix, 32'h0);

        // Live channels: 1-cycle ack, quiet bus either side, pre-update read.
        user_live[2*UW +: UW] = 32'hDEAD_BEEF;
        tick(2);
        rd(32'h10);
        check("live_ack", {30'b0, r_ack}, 32'h3);
        check("live_ch2", r_live, 32'hDEAD_BEEF);
        check("live_idle", r_side, 32'h0);
        user_live[2*UW +: UW] = 32'h1234_5678;
        rd(32'h10);
        check("live_same_cycle", r_live, 32'hDEAD_BEEF);
        rd(32'h10);
        check("live_updated", r_live, 32'h1234_5678);
        user_live[0 +: UW] = 32'hA5A5_0001;
        tick(2);
        rd(32'h08);
        check("live_ch0", r_live, 32'hA5A5_0001);
        rd(32'h00);
        check("ctrl_reads_zero", r_live, 32'h0);

        // Sticky ch1: accumulate, W1C, set-wins, byte enables, clear-all.
        user_mix[UW +: UW] = 32'h5; tick(1); user_mix[UW +: UW] = 32'h0; tick(1);
        rd(32'h0C);
        check("sticky_hold", r_mix, 32'h5);
        wr(32'h0C, 32'h1, 4'hF, 1'b0);
        check("sticky_wr_ack", {30'b0, r_ack}, 32'h3);
        rd(32'h0C);
        check("sticky_w1c", r_mix, 32'h4);
        user_mix[UW +: UW] = 32'h1;
        abus = 32'h0C; rnw = 1'b0; dbus = 32'h5; be = 4'hF; sel = 1'b1;
        @(posedge clk); #1;
        user_mix[UW +: UW] = 32'h0;
        sel = 1'b0; abus = '0; dbus = '0; be = '0;
        tick(1);
        rd(32'h0C);
        check("sticky_set_wins", r_mix, 32'h1);
        user_mix[UW +: UW] = 32'hFFFF_FFFF; tick(1); user_mix[UW +: UW] = 32'h0;
        wr(32'h0C, 32'hFFFF_FFFF, 4'b0001, 1'b0);
        rd(32'h0C);
        check("sticky_be", r_mix, 32'hFFFF_FF00);
        wr(32'h00, 32'h2, 4'hF, 1'b0);
        rd(32'h0C);
        check("sticky_clr_all", r_mix, 32'h0);

        // Snapshot ch2/ch3.
        user_mix[2*UW +: UW] = 32'h11; user_mix[3*UW +: UW] = 32'h22;
        tick(1);
        snap_in = 1'b1; tick(1); snap_in = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        user_mix[2*UW +: UW] = 32'h33; user_mix[3*UW +: UW] = 32'h44;
        tick(2);
        rd(32'h10);
        check("snap_ch2", r_mix, 32'h11);
        rd(32'h14);
        check("snap_ch3", r_mix, 32'h22);
        rd(32'h04);
        check("snap_stat1", r_mix, 32'h1);
        wr(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd(32'h10);
        check("snap_wr_ignored", r_mix, 32'h11);
        wr(32'h00, 32'h1, 4'hF, 1'b1);
        exp_cnt = exp_cnt + 16'd1;
        rd(32'h04);
        check("snap_stat2", r_mix, {16'h0, exp_cnt});
        rd(32'h10);
        check("snap2_ch2", r_mix, 32'h33);
        rd(32'h14);
        check("snap2_ch3", r_mix, 32'h44);

        // Held select: ack pulses on alternate cycles.
        abus = 32'h04; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        @(posedge clk); #1; check("alt_ack_1", {31'b0, ack_mix}, 32'h1);
        @(posedge clk); #1; check("alt_ack_2", {31'b0, ack_mix}, 32'h0);
        @(posedge clk); #1; check("alt_ack_3", {31'b0, ack_mix}, 32'h1);
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
        tick(1);

        // Counter wrap.
        n_wrap = 32'hFFFF - int'(exp_cnt);
        snap_in = 1'b1;
        tick(n_wrap);
        snap_in = 1'b0;
        exp_cnt = 16'hFFFF;
        check("cnt_max", {16'h0, cnt_mix}, {16'h0, exp_cnt});
        snap_in = 1'b1; tick(1); snap_in = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("cnt_wrap", {16'h0, cnt_mix}, 32'h0);
        rd(32'h04);
        check("stat_wrap", r_mix, {16'h0, exp_cnt});

        // Unmapped offset inside the window, then outside the window.
        rd(32'h40);
        check("oor_ack", {30'b0, r_ack}, 32'h3);
        check("oor_data", r_live | r_mix, 32'h0);
        rd(32'h100);
        check("miss_ack", {30'b0, r_ack}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
